// File: rtl/mem_arbiter_if.sv
// Bus between the arbiter and the shared SPI flash read engine.
interface mem_arbiter_if;
  logic        mem_start;
  logic [23:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_rdata;

  modport master (output mem_start, output mem_addr, input mem_done, input mem_rdata);
  modport slave  (input mem_start, input mem_addr, output mem_done, output mem_rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single SPI flash read engine.
// Port 0 is instruction fetch, port 1 is data load. One transaction at a
// time; the engine start line is held for the whole transaction, and a
// RELEASE cycle plus an IDLE cycle guarantee a two-cycle low gap on start.
module mem_arbiter #(
  parameter bit ROUND_ROBIN    = 1'b1,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TIMEOUT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [23:0]        addr0,
  output logic               ack0,
  output logic [31:0]        rdata0,
  output logic               err0,
  input  logic               req1,
  input  logic [23:0]        addr1,
  output logic               ack1,
  output logic [31:0]        rdata1,
  output logic               err1,
  mem_arbiter_if.master      mem,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // Counter value on which the transaction is abandoned (unused when 0).
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]           state_reg;
  logic                 grant_reg;
  logic                 last_grant_reg;
  logic [TIMEOUT_W-1:0] cnt_reg;
  logic                 start_reg;
  logic [23:0]          addr_reg;
  logic                 busy_reg;

  logic                 ack_reg   [2];
  logic                 err_reg   [2];
  logic [31:0]          rdata_reg [2];

  logic [1:0]           req_vec;
  logic [23:0]          addr_vec  [2];
  logic                 pick;
  logic                 done_ok;
  logic                 done_to;

  assign req_vec     = {req1, req0};
  assign addr_vec[0] = addr0;
  assign addr_vec[1] = addr1;

  // Arbitration winner for the IDLE cycle.
  always_comb begin
    pick = 1'b0;
    if (req_vec == 2'b11) begin
      pick = ROUND_ROBIN ? ~last_grant_reg : 1'b1;
    end else begin
      pick = req_vec[1];
    end
  end

  // Completion events; engine done wins over a timeout in the same cycle.
  assign done_ok = (state_reg == ST_BUSY) && mem.mem_done;
  assign done_to = (state_reg == ST_BUSY) && !mem.mem_done &&
                   (TIMEOUT_CYCLES != 0) && (cnt_reg == TO_LAST);

  // Transaction sequencing: grant, hold the engine, release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      start_reg      <= 1'b0;
      addr_reg       <= '0;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      cnt_reg        <= '0;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|req_vec) begin
            state_reg <= ST_BUSY;
            start_reg <= 1'b1;
            addr_reg  <= addr_vec[pick];
            grant_reg <= pick;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        ST_BUSY: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (done_ok || done_to) begin
            state_reg <= ST_RELEASE;
            start_reg <= 1'b0;
          end
          if (done_ok) begin
            last_grant_reg <= grant_reg;
          end
        end
        ST_RELEASE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          start_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    // Per-port ack pulse, sticky error flag and held read data.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ack_reg[gi]   <= 1'b0;
        err_reg[gi]   <= 1'b0;
        rdata_reg[gi] <= '0;
      end else begin
        ack_reg[gi] <= (done_ok || done_to) && (grant_reg == 1'(gi));
        if ((done_ok || done_to) && (grant_reg == 1'(gi))) begin
          err_reg[gi] <= done_to;
          if (done_ok) begin
            rdata_reg[gi] <= mem.mem_rdata;
          end
        end
      end
    end
  end

  assign ack0          = ack_reg[0];
  assign ack1          = ack_reg[1];
  assign err0          = err_reg[0];
  assign err1          = err_reg[1];
  assign rdata0        = rdata_reg[0];
  assign rdata1        = rdata_reg[1];
  assign mem.mem_start = start_reg;
  assign mem.mem_addr  = addr_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter. Two instances: round-robin with a
// 16-cycle timeout, and fixed priority with the default timeout. Each is
// checked against a transaction-level model of pending requests, grant
// history and per-port result registers.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s    [2];
  logic        req0_s   [2];
  logic        req1_s   [2];
  logic [23:0] addr0_s  [2];
  logic [23:0] addr1_s  [2];
  logic        ack0_s   [2];
  logic        ack1_s   [2];
  logic        err0_s   [2];
  logic        err1_s   [2];
  logic [31:0] rdata0_s [2];
  logic [31:0] rdata1_s [2];
  logic        busy_s   [2];
  logic        done_s   [2];
  logic [31:0] mrdata_s [2];
  logic        start_s  [2];
  logic [23:0] maddr_s  [2];

  mem_arbiter_if bus_a ();
  mem_arbiter_if bus_b ();

  assign bus_a.mem_done  = done_s[0];
  assign bus_a.mem_rdata = mrdata_s[0];
  assign start_s[0]      = bus_a.mem_start;
  assign maddr_s[0]      = bus_a.mem_addr;
  assign bus_b.mem_done  = done_s[1];
  assign bus_b.mem_rdata = mrdata_s[1];
  assign start_s[1]      = bus_b.mem_start;
  assign maddr_s[1]      = bus_b.mem_addr;

  mem_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(16)) u_rr (
    .clk(clk), .rst_n(rst_s[0]),
    .req0(req0_s[0]), .addr0(addr0_s[0]), .ack0(ack0_s[0]), .rdata0(rdata0_s[0]), .err0(err0_s[0]),
    .req1(req1_s[0]), .addr1(addr1_s[0]), .ack1(ack1_s[0]), .rdata1(rdata1_s[0]), .err1(err1_s[0]),
    .mem(bus_a), .busy(busy_s[0])
  );

  mem_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(1023)) u_fp (
    .clk(clk), .rst_n(rst_s[1]),
    .req0(req0_s[1]), .addr0(addr0_s[1]), .ack0(ack0_s[1]), .rdata0(rdata0_s[1]), .err0(err0_s[1]),
    .req1(req1_s[1]), .addr1(addr1_s[1]), .ack1(ack1_s[1]), .rdata1(rdata1_s[1]), .err1(err1_s[1]),
    .mem(bus_b), .busy(busy_s[1])
  );

  // Configuration of each instance as seen by the model.
  int rr_cfg [2] = '{1, 0};
  int to_cfg [2] = '{16, 1023};

  // Reference model state.
  int          last_g [2];
  logic [31:0] rd_exp [2][2];
  logic        er_exp [2][2];
  bit          pend   [2][2];
  logic [23:0] addr_m [2][2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic ack_of(input int d, input int p);
    return (p == 0) ? ack0_s[d] : ack1_s[d];
  endfunction

  function automatic logic err_of(input int d, input int p);
    return (p == 0) ? err0_s[d] : err1_s[d];
  endfunction

  function automatic logic [31:0] rdata_of(input int d, input int p);
    return (p == 0) ? rdata0_s[d] : rdata1_s[d];
  endfunction

  task automatic set_req(input int d, input int p, input logic v);
    if (p == 0) begin
      req0_s[d]  = v;
      addr0_s[d] = addr_m[d][0];
    end else begin
      req1_s[d]  = v;
      addr1_s[d] = addr_m[d][1];
    end
  endtask

  task automatic model_reset(input int d);
    last_g[d] = 1;
    for (int p = 0; p < 2; p++) begin
      rd_exp[d][p] = '0;
      er_exp[d][p] = 1'b0;
      pend[d][p]   = 1'b0;
      addr_m[d][p] = '0;
      set_req(d, p, 1'b0);
    end
  endtask

  task automatic check_reset(input int d);
    check("rst_start", start_s[d], 0);
    check("rst_addr", maddr_s[d], 0);
    check("rst_ack", {ack0_s[d], ack1_s[d]}, 0);
    check("rst_err", {err0_s[d], err1_s[d]}, 0);
    check("rst_rdata", {rdata0_s[d], rdata1_s[d]}, 0);
    check("rst_busy", busy_s[d], 0);
  endtask

  // One arbitration round starting from an IDLE-cycle negedge.
  task automatic do_txn(input int d, input bit want0, input bit want1,
                        input logic [23:0] a0, input logic [23:0] a1,
                        input int done_at, input bit hang,
                        input logic [31:0] data, input int rst_at);
    int w;
    int i;
    int lat_exp;
    if (want0 && !pend[d][0]) begin pend[d][0] = 1'b1; addr_m[d][0] = a0; set_req(d, 0, 1'b1); end
    if (want1 && !pend[d][1]) begin pend[d][1] = 1'b1; addr_m[d][1] = a1; set_req(d, 1, 1'b1); end
    // Spurious engine activity while idle must be ignored.
    if ($urandom_range(0, 3) == 0) begin
      done_s[d]   = 1'b1;
      mrdata_s[d] = $urandom;
    end
    if (!pend[d][0] && !pend[d][1]) begin
      @(negedge clk);
      done_s[d] = 1'b0;
      check("idle_start", start_s[d], 0);
      check("idle_ack", {ack0_s[d], ack1_s[d]}, 0);
      check("idle_busy", busy_s[d], 0);
      $display("txn dut=%0d idle", d);
      return;
    end
    if (pend[d][0] && pend[d][1]) w = (rr_cfg[d] != 0) ? 1 - last_g[d] : 1;
    else w = pend[d][1] ? 1 : 0;

    @(negedge clk);
    done_s[d] = 1'b0;
    check("start_rise", start_s[d], 1);
    check("grant_addr", maddr_s[d], addr_m[d][w]);
    check("busy_on", busy_s[d], 1);

    if (rst_at > 0) begin
      repeat (rst_at - 1) @(negedge clk);
      rst_s[d] = 1'b0;
      model_reset(d);
      @(negedge clk);
      rst_s[d] = 1'b1;
      check_reset(d);
      $display("txn dut=%0d port=%0d reset after %0d cycles", d, w, rst_at);
      return;
    end

    i = 1;
    while (1) begin
      if (!hang && i == done_at) begin
        done_s[d]   = 1'b1;
        mrdata_s[d] = data;
      end
      @(negedge clk);
      done_s[d] = 1'b0;
      if (ack0_s[d] || ack1_s[d] || !start_s[d]) break;
      i++;
      if (i > 2000) break;
    end
    lat_exp = hang ? to_cfg[d] : done_at;
    check("latency", i, lat_exp);
    if (i > 2000) return;
    check("ack_win", ack_of(d, w), 1);
    check("ack_other", ack_of(d, 1 - w), 0);
    check("start_fall", start_s[d], 0);
    check("busy_rel", busy_s[d], 1);
    if (!hang) begin
      rd_exp[d][w] = data;
      er_exp[d][w] = 1'b0;
      last_g[d]    = w;
    end else begin
      er_exp[d][w] = 1'b1;
    end
    for (int p = 0; p < 2; p++) begin
      check(p == 0 ? "rdata0" : "rdata1", rdata_of(d, p), rd_exp[d][p]);
      check(p == 0 ? "err0" : "err1", err_of(d, p), er_exp[d][p]);
    end
    pend[d][w] = 1'b0;
    set_req(d, w, 1'b0);
    @(negedge clk);
    check("ack_pulse", {ack0_s[d], ack1_s[d]}, 0);
    check("gap_start", start_s[d], 0);
    check("busy_off", busy_s[d], 0);
    $display("txn dut=%0d port=%0d addr=%06h lat=%0d timeout=%0d rdata=%08h",
             d, w, addr_m[d][w], i, hang, rd_exp[d][w]);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d]    = 1'b0;
      done_s[d]   = 1'b0;
      mrdata_s[d] = '0;
      model_reset(d);
    end
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_s[0] = 1'b1;
    rst_s[1] = 1'b1;

    // Round-robin instance: steady contention alternates 0,1,0,1.
    repeat (4) do_txn(0, 1'b1, 1'b1, 24'h000010, 24'h000020, 3, 1'b0, $urandom, 0);
    // Timeout on port 1, then a successful read clears its error.
    do_txn(0, 1'b0, 1'b1, 24'h0, 24'h000030, 0, 1'b1, 32'h0, 0);
    do_txn(0, 1'b0, 1'b1, 24'h0, 24'h000031, 5, 1'b0, $urandom, 0);
    // Done on the very cycle the timeout would expire counts as success.
    do_txn(0, 1'b1, 1'b0, 24'h000040, 24'h0, 16, 1'b0, $urandom, 0);
    // Reset during BUSY, then a clean restart.
    do_txn(0, 1'b1, 1'b1, 24'h000050, 24'h000060, 0, 1'b0, 32'h0, 5);
    do_txn(0, 1'b1, 1'b0, 24'h000070, 24'h0, 2, 1'b0, $urandom, 0);
    for (int n = 0; n < 60; n++) begin
      do_txn(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             24'($urandom), 24'($urandom), $urandom_range(1, 16),
             ($urandom_range(0, 4) == 0), $urandom,
             ($urandom_range(0, 19) == 0) ? $urandom_range(1, 10) : 0);
    end

    // Fixed-priority instance: long single read first.
    do_txn(1, 1'b1, 1'b0, 24'h000100, 24'h0, 270, 1'b0, 32'hDEADBEEF, 0);
    // Port 1 wins every tie; port 0 only once port 1 stops asking.
    repeat (3) do_txn(1, 1'b1, 1'b1, 24'h000200, 24'h000300, 4, 1'b0, $urandom, 0);
    do_txn(1, 1'b0, 1'b0, 24'h0, 24'h0, 4, 1'b0, $urandom, 0);
    for (int n = 0; n < 30; n++) begin
      do_txn(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             24'($urandom), 24'($urandom), $urandom_range(1, 300), 1'b0, $urandom,
             ($urandom_range(0, 14) == 0) ? $urandom_range(1, 10) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single SPI flash read engine (start/done handshake, 24-bit address, 32-bit read data) between two requesters: port 0 is instruction fetch and port 1 is data load.
- Grants one requester at a time and holds the engine's start line for the whole transaction.
- Returns the read word and a one-cycle ack to the granted port.
- Enforces an idle gap between transactions and aborts any transaction that exceeds a programmable timeout.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate the grant when both ports are pending; 0 = fixed priority, port 1 always wins.
- TIMEOUT_CYCLES, 1023, max clk cycles in BUSY before abort; 0 disables the timeout.
- TIMEOUT_W, 16, width of the timeout counter; TIMEOUT_CYCLES must be < 2^TIMEOUT_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- req0  in  1  port 0 request.
- addr0  in  24  port 0 byte address.
- ack0  out  1  port 0 completion pulse.
- rdata0  out  32  port 0 read data.
- err0  out  1  port 0 timeout flag.
- req1  in  1  port 1 request.
- addr1  in  24  port 1 byte address.
- ack1  out  1  port 1 completion pulse.
- rdata1  out  32  port 1 read data.
- err1  out  1  port 1 timeout flag.
- mem_start  out  1  engine start/hold; high for the whole transaction.
- mem_addr  out  24  engine target address.
- mem_done  in  1  engine done; valid only while mem_start is high.
- mem_rdata  in  32  engine read data; valid when mem_done is high.
- busy  out  1  high in BUSY and RELEASE.

Interface rule: reset rst_n, synchronous, active-low; clock clk.

Behaviour:
- All outputs are registered. On a clk edge with rst_n=0:
  - state=IDLE; mem_start=0; mem_addr=0.
  - ack0=ack1=0; err0=err1=0; rdata0=rdata1=0.
  - last_grant=1, so port 0 wins the first tie; timeout counter=0.
- Reset mid-transaction: mem_start drops on the next edge and no ack is issued. The engine returns to its start state because start is low.
- Requester contract:
  - Hold req high and addr stable until ack.
  - Drop req in the cycle after ack unless issuing a new request.
  - req is sampled only in IDLE.
- States:
  - IDLE: if any req is high, choose a winner and latch its address. Next cycle: state=BUSY, mem_start=1, mem_addr=addrN, grant=N, counter=0.
  - BUSY: mem_start stays 1, mem_addr stays stable, counter increments.
    - mem_done=1 → next cycle: RELEASE, mem_start=0, ackN=1, rdataN=mem_rdata, errN=0, last_grant=N.
    - Otherwise, if TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1 → next cycle: RELEASE, mem_start=0, ackN=1, errN=1, rdataN unchanged.
    - mem_done takes precedence over timeout in the same cycle.
  - RELEASE: ack cleared next cycle; unconditional transition to IDLE; mem_start stays 0.
- mem_start is low for at least 2 cycles between transactions (RELEASE plus IDLE). Best-case turnaround from one mem_done to the next mem_start rise is 3 edges.
- Arbitration:
  - Only one req high → that port wins.
  - Both high, ROUND_ROBIN=1 → the port ≠ last_grant wins.
  - Both high, ROUND_ROBIN=0 → port 1 wins.
- Latency: req rises in IDLE at cycle T → mem_start=1 at T+1. mem_done at cycle M → ack at M+1.
- ack0/ack1 are single-cycle pulses, never asserted simultaneously.
- rdataN holds its value until the next successful ack on that port. errN holds until the next ack on that port.
- The losing request stays pending, with no loss, and is served after RELEASE.
- mem_done or mem_rdata arriving in IDLE or RELEASE is ignored.

Test Plan:
1. Single read: req0=1, addr0=24'h000100; engine model asserts mem_done with mem_rdata=32'hDEADBEEF 270 cycles after start → mem_start rises 1 cycle after req0 with mem_addr=24'h000100; ack0 pulses 1 cycle after mem_done; rdata0=32'hDEADBEEF; err0=0; ack1 never fires.
2. Contention with ROUND_ROBIN=1: req0 and req1 both held high continuously after reset, distinct addresses 24'h10 and 24'h20 → grant order 0,1,0,1; mem_start low exactly 2 cycles between transactions; each ack returns its own data.
3. Fixed priority, ROUND_ROBIN=0: both requests held for 3 transactions → all 3 granted to port 1; port 0 is served only after req1 drops.
4. Timeout, TIMEOUT_CYCLES=16: engine never asserts mem_done → mem_start falls 16 cycles after rising; ack1=1 and err1=1; rdata1 keeps its previous value; next grant proceeds normally and its successful ack clears err1.
5. Reset mid-transaction: rst_n=0 for 1 cycle during BUSY → mem_start=0 on the next edge; no ack; all outputs equal reset values; a new req after reset starts cleanly.
6. Edge cases: mem_done asserted on the same cycle as the timeout expiry → treated as success with err=0; a spurious mem_done in IDLE → no ack.
